ps2_key_ctrl: RTL and testbench

//   Sequencer between ps2_keyboard's byte FIFO and the display/seg consumers. Pops

---
 rtl/ps2_key_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl
// Purpose  : Pops PS/2 scan-code bytes, decodes make/break/extended codes,
//            tracks the held key and keeps a 2-digit BCD press counter.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter logic [7:0] BREAK_CODE  = 8'hF0,
    parameter logic [7:0] EXT_CODE    = 8'hE0,
    parameter int         PFX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ready,
    input  logic [7:0] data,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_held,
    output logic       key_evt,
    output logic [7:0] press_cnt_bcd,
    output logic       ovf_sticky
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_nextdata_n;

    logic [7:0] r_byte;
    logic       r_brk_pend;
    logic       r_ext_pend;
    logic [7:0] r_key_code;
    logic       r_key_ext;
    logic       r_key_held;
    logic       r_key_evt;
    logic [7:0] r_cnt_bcd;
    logic       r_ovf_sticky;

    logic       w_decode;
    logic       w_is_ext;
    logic       w_is_brk;
    logic       w_is_code;
    logic       w_same_key;
    logic       w_new_press;
    logic       w_release;
    logic       w_timeout;
    logic [7:0] w_cnt_inc;

    // ------------------------------------------------------------------------
    // Sequencer: IDLE -> POP -> DECODE gives the FIFO one cycle to advance.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_nextdata_n = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (ready) begin
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_nextdata_n = 1'b0;
                w_state_nxt  = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_byte <= 8'h00;
        end else if (r_state == S_IDLE && ready) begin
            r_byte <= data;
        end
    end

    // ------------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------------
    assign w_decode    = (r_state == S_DECODE);
    assign w_is_ext    = (r_byte == EXT_CODE);
    assign w_is_brk    = (r_byte == BREAK_CODE);
    assign w_is_code   = w_decode && !w_is_ext && !w_is_brk;
    assign w_same_key  = r_key_held && (r_key_ext == r_ext_pend) && (r_key_code == r_byte);
    assign w_new_press = w_is_code && !r_brk_pend && !w_same_key;
    assign w_release   = w_is_code && r_brk_pend;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
        end else if (w_timeout) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
        end else if (w_decode) begin
            if (w_is_ext) begin
                r_ext_pend <= 1'b1;
            end else if (w_is_brk) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Held-key tracking and event strobe
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_key_code <= 8'h00;
            r_key_ext  <= 1'b0;
            r_key_held <= 1'b0;
            r_key_evt  <= 1'b0;
        end else begin
            r_key_evt <= w_new_press;
            if (w_new_press) begin
                r_key_code <= r_byte;
                r_key_ext  <= r_ext_pend;
                r_key_held <= 1'b1;
            end else if (w_release && w_same_key) begin
                r_key_held <= 1'b0;
            end
        end
    end

    // BCD increment, 99 wraps to 00
    always_comb begin
        w_cnt_inc = r_cnt_bcd;
        if (r_cnt_bcd[3:0] == 4'd9) begin
            w_cnt_inc[3:0] = 4'd0;
            w_cnt_inc[7:4] = (r_cnt_bcd[7:4] == 4'd9) ? 4'd0 : (r_cnt_bcd[7:4] + 4'd1);
        end else begin
            w_cnt_inc[3:0] = r_cnt_bcd[3:0] + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt_bcd <= 8'h00;
        end else if (w_new_press) begin
            r_cnt_bcd <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovf_sticky <= 1'b0;
        end else if (overflow) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Pending-prefix timeout: a lone F0/E0 with no follow-up byte is dropped.
    // ------------------------------------------------------------------------
    generate
        if (PFX_TIMEOUT > 0) begin : g_pfx_timeout
            localparam int              c_TW      = $clog2(PFX_TIMEOUT + 1);
            localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(PFX_TIMEOUT - 1);
            localparam logic [c_TW-1:0] c_ONE     = c_TW'(1);

            logic [c_TW-1:0] r_to_cnt;
            logic            w_run;

            assign w_run     = (r_brk_pend || r_ext_pend) && (r_state == S_IDLE) && !ready;
            assign w_timeout = w_run && (r_to_cnt == c_TO_LAST);

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_to_cnt <= '0;
                end else if (r_state == S_POP) begin
                    r_to_cnt <= '0;
                end else if (w_run) begin
                    r_to_cnt <= (r_to_cnt == c_TO_LAST) ? '0 : (r_to_cnt + c_ONE);
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign nextdata_n    = w_nextdata_n;
    assign key_code      = r_key_code;
    assign key_ext       = r_key_ext;
    assign key_held      = r_key_held;
    assign key_evt       = r_key_evt;
    assign press_cnt_bcd = r_cnt_bcd;
    assign ovf_sticky    = r_ovf_sticky;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_ctrl
// Purpose  : Scoreboard bench for ps2_key_ctrl with a FIFO model and a
//            key-state reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_ctrl;

    localparam int c_TO = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_held;
    logic       key_evt;
    logic [7:0] press_cnt_bcd;
    logic       ovf_sticky;

    int total = 0;
    int bad = 0;
    int n_sent = 0;
    int n_pulse = 0;
    int n_evt = 0;
    logic prev_low = 1'b0;

    logic [7:0]  fifo[$];
    logic [16:0] exp_q[$];

    // reference model state
    logic       m_brk, m_ext, m_held, m_hext;
    logic [7:0] m_hcode;
    int         m_cnt;

    ps2_key_ctrl #(
        .BREAK_CODE (8'hF0),
        .EXT_CODE   (8'hE0),
        .PFX_TIMEOUT(c_TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ready        (ready),
        .data         (data),
        .overflow     (overflow),
        .nextdata_n   (nextdata_n),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_held     (key_held),
        .key_evt      (key_evt),
        .press_cnt_bcd(press_cnt_bcd),
        .ovf_sticky   (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic void model_reset();
        m_brk = 1'b0; m_ext = 1'b0; m_held = 1'b0; m_hext = 1'b0;
        m_hcode = 8'h00; m_cnt = 0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic same;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            same = m_held && (m_hext == m_ext) && (m_hcode == b);
            if (m_brk) begin
                if (same) m_held = 1'b0;
            end else if (!same) begin
                m_hcode = b;
                m_hext  = m_ext;
                m_held  = 1'b1;
                m_cnt   = (m_cnt + 1) % 100;
                exp_q.push_back({m_ext, b, to_bcd(m_cnt)});
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endfunction

    // FIFO model: pops on each low nextdata_n, presents head byte
    always @(negedge clk) begin
        if (!nextdata_n) begin
            n_pulse++;
            total++;
            if (prev_low) begin
                bad++;
                $display("FAIL pulse_width: nextdata_n low 2 cycles at %0t", $time);
            end
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        prev_low = !nextdata_n;
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'h00;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [16:0] e;
        if (resetn && key_evt) begin
            n_evt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", {24'h0, key_code}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("evt_code", {24'h0, key_code}, {24'h0, e[15:8]});
                chk("evt_ext", {31'h0, key_ext}, {31'h0, e[16]});
                chk("evt_cnt", {24'h0, press_cnt_bcd}, {24'h0, e[7:0]});
                chk("evt_held", {31'h0, key_held}, 32'h1);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        fifo.push_back(b);
        n_sent++;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(3);
        model_reset();
        resetn = 1'b1;
        cyc(1);
    endtask

    // drain FIFO, idle long enough for any lone prefix to expire, then compare
    task automatic drain(input string tag);
        int budget = 5000;
        while (fifo.size() != 0 && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (budget == 0) chk({tag, "_drain_timeout"}, fifo.size(), 0);
        cyc(30);
        m_brk = 1'b0;
        m_ext = 1'b0;
        @(negedge clk);
        chk({tag, "_held"}, {31'h0, key_held}, {31'h0, m_held});
        chk({tag, "_code"}, {24'h0, key_code}, {24'h0, m_hcode});
        chk({tag, "_ext"}, {31'h0, key_ext}, {31'h0, m_hext});
        chk({tag, "_cnt"}, {24'h0, press_cnt_bcd}, {24'h0, to_bcd(m_cnt)});
        chk({tag, "_evq_empty"}, exp_q.size(), 0);
        chk({tag, "_pulses"}, n_pulse, n_sent);
        cyc(1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] tbl [6];
        int ev0;
        logic [7:0] cnt0;
        int budget;
        tbl[0] = 8'h1C; tbl[1] = 8'h32; tbl[2] = 8'h75;
        tbl[3] = 8'h5A; tbl[4] = 8'hF0; tbl[5] = 8'hE0;
        model_reset();

        // reset with ready asserted
        cyc(1);
        send(8'h1C);
        repeat (3) begin
            @(negedge clk);
            chk("rst_nextdata_n", {31'h0, nextdata_n}, 32'h1);
            chk("rst_code", {24'h0, key_code}, 32'h0);
            chk("rst_held", {31'h0, key_held}, 32'h0);
            chk("rst_evt", {31'h0, key_evt}, 32'h0);
            chk("rst_cnt", {24'h0, press_cnt_bcd}, 32'h0);
            chk("rst_ovf", {31'h0, ovf_sticky}, 32'h0);
        end
        chk("rst_ready_seen", {31'h0, ready}, 32'h1);
        cyc(1);
        resetn = 1'b1;
        drain("t1");

        // make / break
        do_reset();
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain("t2");
        chk("t2_cnt_const", {24'h0, press_cnt_bcd}, 32'h01);

        // typematic + extended
        do_reset();
        ev0 = n_evt;
        foreach (tbl[i]) if (i < 0) ev0 = ev0;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hE0);
        send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain("t3");
        chk("t3_evts", n_evt - ev0, 2);
        chk("t3_code_const", {24'h0, key_code}, 32'h75);
        chk("t3_ext_const", {31'h0, key_ext}, 32'h1);
        chk("t3_cnt_const", {24'h0, press_cnt_bcd}, 32'h02);

        // randomized traffic with short gaps
        for (int i = 0; i < 300; i++) begin
            send(tbl[$urandom_range(0, 5)]);
            cyc($urandom_range(0, 4));
        end
        drain("rnd");

        // counter wrap
        do_reset();
        for (int i = 0; i < 100; i++) begin
            logic [7:0] k;
            k = (i % 2 == 0) ? 8'h1C : 8'h32;
            send(k); send(8'hF0); send(k);
        end
        drain("t4");
        chk("t4_cnt_const", {24'h0, press_cnt_bcd}, 32'h00);

        // prefix timeout
        cnt0 = press_cnt_bcd;
        send(8'hF0);
        drain("t5a");
        send(8'h1C);
        drain("t5");
        chk("t5_held_const", {31'h0, key_held}, 32'h1);
        chk("t5_cnt_inc", {24'h0, press_cnt_bcd}, {24'h0, to_bcd((int'(cnt0[7:4]) * 10 + int'(cnt0[3:0]) + 1) % 100)});

        // overflow sticky, then reset during POP
        overflow = 1'b1;
        cyc(1);
        overflow = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("t6_ovf_set", {31'h0, ovf_sticky}, 32'h1);
        send(8'hF0);
        budget = 200;
        do begin
            @(negedge clk);
            budget--;
        end while (nextdata_n && budget > 0);
        chk("t6_pop_seen", {31'h0, nextdata_n}, 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        chk("t6_nextdata_n", {31'h0, nextdata_n}, 32'h1);
        chk("t6_ovf_clr", {31'h0, ovf_sticky}, 32'h0);
        chk("t6_held", {31'h0, key_held}, 32'h0);
        chk("t6_cnt", {24'h0, press_cnt_bcd}, 32'h0);
        model_reset();
        cyc(1);
        resetn = 1'b1;
        send(8'h32);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
